// File: rtl/scan_pkg.sv
// Shared encodings and widths for the 4:1 mux scan sequencer.
package scan_pkg;

    localparam int CH_N  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_next_channel.sv
// Round-robin channel search: the first enabled channel after last_ch, with wrap-around.
// When only last_ch is enabled the search returns last_ch itself.
module rr_next_channel
    import scan_pkg::*;
(
    input  logic [CH_N-1:0]  ch_mask_i,
    input  logic [SEL_W-1:0] last_ch_i,
    output logic [SEL_W-1:0] next_ch_o,
    output logic             found_o
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset to the nearest so the nearest enabled channel wins.
    always_comb begin
        next_ch_o = last_ch_i;
        found_o   = 1'b0;
        idx       = '0;
        for (int k = CH_N; k >= 1; k--) begin
            idx = SEL_W'(int'(last_ch_i) + k);
            if (ch_mask_i[idx]) begin
                next_ch_o = idx;
                found_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Round-robin scanner for a 4:1 data mux: drives sel, waits DWELL cycles, captures mux_out
// and presents it on a valid/ready stream. Define SCAN_PARITY_EN to add the out_parity output.
//
// state  | meaning
// IDLE   | not scanning; waits for enable with a non-empty mask
// SETTLE | sel driven, counting down the settling dwell
// HOLD   | sample presented, waiting for out_ready
module mux4_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DWELL  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [3:0]        ch_mask,
    input  logic [DATA_W-1:0] mux_out,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_ch,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef SCAN_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_ch_q, last_ch_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
`ifdef SCAN_PARITY_EN
    logic               out_parity_q, out_parity_d;
`endif

    logic [SEL_W-1:0]   next_ch;
    logic               found;
    logic               handshake;
    logic               restart;

    rr_next_channel u_rr_next_channel (
        .ch_mask_i (ch_mask),
        .last_ch_i (last_ch_q),
        .next_ch_o (next_ch),
        .found_o   (found)
    );

    assign handshake = out_valid_q && out_ready;
    // found implies a non-empty mask
    assign restart   = enable && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (restart) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable)         state_d = ST_IDLE;
                else if (cnt_q == '0) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) state_d = restart ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        last_ch_d    = last_ch_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
`ifdef SCAN_PARITY_EN
        out_parity_d = out_parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    sel_d = next_ch;
                    cnt_d = DWELL_LOAD;
                end
            end
            ST_SETTLE: begin
                if (enable) begin
                    if (cnt_q == '0) begin
                        out_data_d   = mux_out;
                        out_ch_d     = sel_q;
                        last_ch_d    = sel_q;
                        out_valid_d  = 1'b1;
`ifdef SCAN_PARITY_EN
                        out_parity_d = ^mux_out;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (restart) begin
                        sel_d = next_ch;
                        cnt_d = DWELL_LOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= '0;
            last_ch_q    <= SEL_W'(CH_N - 1);
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
`ifdef SCAN_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            last_ch_q    <= last_ch_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
`ifdef SCAN_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef SCAN_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer: directed scenarios against a cycle-level behavioural model.
module tb_mux4_scan_sequencer;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [7:0] mux_out;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid;
    logic       busy;

    always #5 clk = ~clk;

    function automatic logic [7:0] mux_val(input logic [1:0] s);
        case (s)
            2'd0:    return 8'hAA;
            2'd1:    return 8'h55;
            2'd2:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    assign mux_out = mux_val(sel);

    mux4_scan_sequencer #(.DATA_W(8), .DWELL(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .mux_out   (mux_out),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge counter and log of accepted samples
    int cyc = 0;
    int log_ch[$];
    int log_data[$];
    int log_cyc[$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            log_ch.push_back(int'(out_ch));
            log_data.push_back(int'(out_data));
            log_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Behavioural model: scheduled capture time instead of a dwell counter
    logic       m_busy, m_valid;
    logic [1:0] m_sel, m_ch, m_last;
    logic [7:0] m_data;
    int         m_cap_at;
    int         m_edge;

    function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            if (m[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
        end
        return last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_sel = 2'd0; m_ch = 2'd0;
            m_last = 2'd3; m_data = 8'h00; m_cap_at = -1; m_edge = 0;
        end else begin
            if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    if (enable && ch_mask != 4'b0) begin
                        m_sel = pick(ch_mask, m_last);
                        m_cap_at = m_edge + DW;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end else if (m_busy) begin
                if (!enable) begin
                    m_busy = 1'b0;
                end else if (m_edge == m_cap_at) begin
                    m_data  = mux_val(m_sel);
                    m_ch    = m_sel;
                    m_last  = m_sel;
                    m_valid = 1'b1;
                end
            end else if (enable && ch_mask != 4'b0) begin
                m_sel    = pick(ch_mask, m_last);
                m_busy   = 1'b1;
                m_cap_at = m_edge + DW;
            end
            m_edge++;
        end
    end

    logic odd_sel_seen = 1'b0;
    logic valid_seen   = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("model sel",       sel,       m_sel);
            check("model out_valid", out_valid, m_valid);
            check("model out_data",  out_data,  m_data);
            check("model out_ch",    out_ch,    m_ch);
            check("model busy",      busy,      m_busy);
            if (busy && sel[0]) odd_sel_seen = 1'b1;
            if (out_valid) valid_seen = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; ch_mask = 4'b0000;
        tick(2);
        log_ch.delete(); log_data.delete(); log_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (out_valid) break;
            tick(1);
        end
        check("wait_valid", out_valid, 1'b1);
    endtask

    task automatic wait_log(input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (log_ch.size() >= n) break;
            tick(1);
        end
        check("wait_log size", log_ch.size() >= n, 1'b1);
    endtask

    int start_c;
    int exp_ch1[5]   = '{0, 1, 2, 3, 0};
    int exp_dat1[5]  = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'hAA};
    int exp_ch2[4]   = '{0, 2, 0, 2};
    int exp_dat2[4]  = '{8'hAA, 8'hFF, 8'hAA, 8'hFF};

    initial begin
        // Reset state
        tick(2);
        check("rst sel", sel, 2'd0);
        check("rst out_data", out_data, 8'h00);
        check("rst out_ch", out_ch, 2'd0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);

        // Scenario 1: full mask, free-running consumer
        do_reset();
        ch_mask = 4'b1111; out_ready = 1'b1; enable = 1'b1;
        start_c = cyc;
        wait_log(5, 40);
        for (int i = 0; i < 5; i++) begin
            if (i < log_ch.size()) begin
                check("s1 ch", log_ch[i], exp_ch1[i]);
                check("s1 data", log_data[i], exp_dat1[i]);
                if (i == 0) check("s1 first latency", log_cyc[0] - start_c, 5);
                else        check("s1 period", log_cyc[i] - log_cyc[i-1], 5);
            end
        end

        // Scenario 2: mask 0101
        do_reset();
        odd_sel_seen = 1'b0;
        ch_mask = 4'b0101; out_ready = 1'b1; enable = 1'b1;
        wait_log(4, 40);
        for (int i = 0; i < 4; i++) begin
            if (i < log_ch.size()) begin
                check("s2 ch", log_ch[i], exp_ch2[i]);
                check("s2 data", log_data[i], exp_dat2[i]);
            end
        end
        check("s2 no odd sel", odd_sel_seen, 1'b0);

        // Scenario 3: back-pressure
        do_reset();
        ch_mask = 4'b1111; out_ready = 1'b0; enable = 1'b1;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("s3 hold valid", out_valid, 1'b1);
            check("s3 hold data", out_data, 8'hAA);
            check("s3 hold ch", out_ch, 2'd0);
            check("s3 hold sel", sel, 2'd0);
        end
        out_ready = 1'b1;
        start_c = cyc;
        wait_log(2, 20);
        if (log_ch.size() >= 2) begin
            check("s3 first ch", log_ch[0], 0);
            check("s3 first data", log_data[0], 8'hAA);
            check("s3 accept edge", log_cyc[0] - start_c, 0);
            check("s3 second ch", log_ch[1], 1);
            check("s3 second data", log_data[1], 8'h55);
            check("s3 second gap", log_cyc[1] - log_cyc[0], 5);
        end

        // Scenario 4a: enable dropped in SETTLE
        do_reset();
        valid_seen = 1'b0;
        ch_mask = 4'b1111; out_ready = 1'b1; enable = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(1);
        check("s4a busy", busy, 1'b0);
        tick(5);
        check("s4a no valid", valid_seen, 1'b0);
        check("s4a no sample", log_ch.size(), 0);

        // Scenario 4b: enable dropped in HOLD
        out_ready = 1'b0; enable = 1'b1;
        wait_valid(20);
        enable = 1'b0;
        tick(2);
        check("s4b still valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick(2);
        check("s4b delivered", log_ch.size(), 1);
        if (log_data.size() >= 1) check("s4b data", log_data[0], 8'hAA);
        check("s4b idle", busy, 1'b0);
        check("s4b valid low", out_valid, 1'b0);

        // Scenario 5: async reset mid-HOLD
        do_reset();
        ch_mask = 4'b1111; out_ready = 1'b0; enable = 1'b1;
        wait_valid(20);
        tick(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s5 async valid", out_valid, 1'b0);
        check("s5 async sel", sel, 2'd0);
        check("s5 async busy", busy, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        log_ch.delete(); log_data.delete(); log_cyc.delete();
        rst_n = 1'b1;
        tick(1);
        out_ready = 1'b1; enable = 1'b1;
        wait_log(1, 20);
        if (log_ch.size() >= 1) begin
            check("s5 restart ch", log_ch[0], 0);
            check("s5 restart data", log_data[0], 8'hAA);
        end

        // Scenario 6: mask change during HOLD, then empty mask
        do_reset();
        ch_mask = 4'b1111; out_ready = 1'b0; enable = 1'b1;
        wait_valid(20);
        check("s6 hold ch", out_ch, 2'd0);
        ch_mask = 4'b1000;
        tick(3);
        out_ready = 1'b1;
        wait_log(2, 20);
        if (log_ch.size() >= 2) begin
            check("s6 next ch", log_ch[1], 3);
            check("s6 next data", log_data[1], 8'h00);
        end
        do_reset();
        ch_mask = 4'b0000; enable = 1'b1; out_ready = 1'b1;
        tick(10);
        check("s6 empty busy", busy, 1'b0);
        check("s6 empty valid", out_valid, 1'b0);
        enable = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
